dma_bus_arbiter: RTL and testbench
==================================

// Module: dma_bus_arbiter
// PURPOSE
//  Shares the CPU address/data bus between the 6502 core and two DMA requesters: OAM block copy (256 B) and DMC sample fetch (1 B).
//  Pulls RDY into the core's dispatch logic to stall it, then masters the bus on a GET/PUT cycle grid.
//  Sits between the APU register file (requests) and the core/bus mux; one CLK edge = one CPU cycle.
// PARAMETERS
//  OAM_LEN   256      bytes per OAM transfer, legal 1..256
//  OAM_PORT  16'h2004 write address for OAM PUT cycles
// PORTS
//  CLK        in   1   CPU cycle clock, all state on rising edge
//  n_RES      in   1   asynchronous, active-low reset
//  CPU_WR     in   1   core's current cycle is a write (RDY cannot halt it)
//  OAM_REQ    in   1   one-cycle pulse: start OAM copy
//  OAM_PAGE   in   8   source page, sampled with OAM_REQ
//  DMC_REQ    in   1   one-cycle pulse: fetch one DMC byte
//  DMC_ADDR   in   16  DMC source address, sampled with DMC_REQ
//  DB_IN      in   8   bus read data
//  RDY        out  1   0 = stall core on next read cycle
//  DMA_OWN    out  1   DMA drives bus this cycle (address mux select)
//  DMA_ADDR   out  16  DMA bus address
//  DMA_RD     out  1   DMA read cycle
//  DMA_WR     out  1   DMA write cycle
//  DB_OUT     out  8   data for OAM PUT (latched GET byte)
//  DMC_ACK    out  1   one-cycle pulse, DB_IN holds DMC byte this cycle
//  PHASE      out  1   0 = GET cycle, 1 = PUT cycle
// BEHAVIOUR
//  - Reset (async): state IDLE, RDY=1, DMA_OWN/RD/WR=0, DMA_ADDR=0, DB_OUT=0, DMC_ACK=0, PHASE=0, pendings cleared.
//  - PHASE toggles every CLK from reset; never paused.
//  - Requests latch a pending flag; RDY=0 from the cycle after pending is set until the cycle after the last DMA cycle.
//  - States: IDLE, HALT, DUMMY, ALIGN, OAM_GET, OAM_PUT, DMC_GET.
//  - IDLE->HALT when any pending. HALT holds while CPU_WR=1 (core finishes writes; up to 3 in a row); first cycle with CPU_WR=0 is the halt cycle, core stalled, DMA_OWN=0.
//  - After halt, DMC path: DUMMY (1 cycle), then ALIGN while PHASE would be PUT, then DMC_GET on GET: DMA_RD=1, DMA_ADDR=DMC_ADDR, DMC_ACK=1.
//  - After halt, OAM path: ALIGN if next cycle is PUT, then OAM_GET (addr={OAM_PAGE,cnt}, DB_OUT<=DB_IN) / OAM_PUT (addr=OAM_PORT, DMA_WR=1) pairs.
//  - cnt 8-bit, reset to 0 on start, +1 after each PUT; done after PUT with cnt==OAM_LEN-1 (255 wraps to 0, no extra cycle).
//  - Total OAM stall: 513 cycles (halt on GET-aligned) or 514 (extra ALIGN).
//  - OAM_REQ and DMC_REQ same cycle: DMC serviced first, shares the halt cycle, OAM follows without re-halt.
//  - OAM_REQ while OAM pending/active: ignored. DMC_REQ while DMC pending: ignored (first address kept).
//  - DMA_OWN=1 exactly in GET/PUT/DMC_GET/DUMMY/ALIGN; core address used otherwise.
//  - n_RES asserted mid-transfer: abort, no further bus cycles, RDY=1 immediately.
// CONFIGURATION
//  DMA_DMC_STEAL_EN defined: DMC pending during OAM takes next GET slot as DMC_GET, following PUT slot is ALIGN (idle), then OAM resumes with deferred GET; cost +2 cycles.
//  Not defined: DMC pending waits until OAM done, then serviced without new HALT (DUMMY, ALIGN as needed, DMC_GET) before RDY returns to 1.
// TESTING
//  1. Reset mid OAM (cnt=0x40) -> next cycle RDY=1, DMA_OWN=0, no DMA_WR after release.
//  2. OAM_REQ page 0x02 on PHASE=1, CPU_WR=0 -> RDY low 513 cycles, reads 0x0200..0x02FF, 256 writes to 0x2004, DB_OUT matches data.
//  3. OAM_REQ with CPU_WR=1 for 3 cycles -> halt delayed 3 cycles, first GET addr 0x0300 for page 0x03.
//  4. DMC_REQ addr 0xC000 alone -> HALT, DUMMY, optional ALIGN, one read 0xC000, DMC_ACK single pulse, stall 3-4 cycles.
//  5. DMC_REQ at OAM cnt=0x10 with DMA_DMC_STEAL_EN -> DMC read inserted, then GET 0x..10 repeated, total 515/516.
//  6. OAM_REQ+DMC_REQ same cycle, no macro -> DMC read precedes first OAM GET, one halt cycle only.

Source files
------------

// File: rtl/dma_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dma_bus_arbiter
//
// Shares the CPU address/data bus between the 6502 core and two DMA
// requesters: the 256-byte OAM block copy and the single-byte DMC sample
// fetch. The core is stalled through RDY. The DMA then masters the bus on
// the alternating GET/PUT cycle grid. One CLK edge is one CPU cycle.
//
// Optional feature macro: DMA_DMC_STEAL_EN
//   defined   : a DMC fetch pending during an OAM copy steals the next GET
//               slot, followed by one idle ALIGN slot, then OAM resumes.
//   undefined : a DMC fetch pending during an OAM copy waits until the copy
//               finishes and is then serviced without a new halt cycle.
//
// Handshake: OAM_REQ / DMC_REQ are single-cycle pulses that are accepted
// only when no request of the same kind is pending. The request address is
// captured in the accepting cycle. DMC_ACK is a single-cycle pulse in the
// cycle where DB_IN carries the fetched DMC byte.
//
// Ports
//   CLK       in   1   CPU cycle clock, rising edge
//   n_RES     in   1   asynchronous active-low reset
//   CPU_WR    in   1   core's current cycle is a write (cannot be halted)
//   OAM_REQ   in   1   pulse: start OAM copy
//   OAM_PAGE  in   8   OAM source page, sampled with OAM_REQ
//   DMC_REQ   in   1   pulse: fetch one DMC byte
//   DMC_ADDR  in   16  DMC source address, sampled with DMC_REQ
//   DB_IN     in   8   bus read data
//   RDY       out  1   0 = core stalled
//   DMA_OWN   out  1   DMA drives the bus this cycle
//   DMA_ADDR  out  16  DMA bus address
//   DMA_RD    out  1   DMA read cycle
//   DMA_WR    out  1   DMA write cycle
//   DB_OUT    out  8   data for OAM PUT (byte latched on the GET)
//   DMC_ACK   out  1   DB_IN holds the DMC byte this cycle
//   PHASE     out  1   0 = GET cycle, 1 = PUT cycle
//   DBG_STATE out  3   current FSM state (debug)
// ---------------------------------------------------------------------------
module dma_bus_arbiter #(
   parameter int unsigned OAM_LEN  = 256,
   parameter logic [15:0] OAM_PORT = 16'h2004
) (
   input  logic        CLK,
   input  logic        n_RES,
   input  logic        CPU_WR,
   input  logic        OAM_REQ,
   input  logic [7:0]  OAM_PAGE,
   input  logic        DMC_REQ,
   input  logic [15:0] DMC_ADDR,
   input  logic [7:0]  DB_IN,
   output logic        RDY,
   output logic        DMA_OWN,
   output logic [15:0] DMA_ADDR,
   output logic        DMA_RD,
   output logic        DMA_WR,
   output logic [7:0]  DB_OUT,
   output logic        DMC_ACK,
   output logic        PHASE,
   output logic [2:0]  DBG_STATE
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HALT    = 3'd1,
      ST_DUMMY   = 3'd2,
      ST_ALIGN   = 3'd3,
      ST_OAM_GET = 3'd4,
      ST_OAM_PUT = 3'd5,
      ST_DMC_GET = 3'd6
   } state_e;

   // A length of 256 truncates to 8'hFF: the counter wraps after the last
   // PUT and no extra cycle is spent.
   localparam logic [7:0] OAM_LAST = 8'(OAM_LEN - 1);

   state_e      state_q, state_d;
   logic        phase_q;
   logic        oam_pend_q, oam_pend_d;
   logic        dmc_pend_q, dmc_pend_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  page_q, page_d;
   logic [15:0] dmc_addr_q, dmc_addr_d;
   logic [7:0]  db_out_q, db_out_d;
   logic        from_dummy_q;
   logic        oam_accept;
   logic        dmc_accept;
   logic        oam_last;

   // Requests of a kind already pending (or an OAM copy in flight) are dropped.
   assign oam_accept = OAM_REQ && !oam_pend_q;
   assign dmc_accept = DMC_REQ && !dmc_pend_q;
   assign oam_last   = (cnt_q == OAM_LAST);

   always_ff @(posedge CLK or negedge n_RES) begin
      if (!n_RES) begin
         state_q      <= ST_IDLE;
         phase_q      <= 1'b0;
         oam_pend_q   <= 1'b0;
         dmc_pend_q   <= 1'b0;
         cnt_q        <= 8'h00;
         page_q       <= 8'h00;
         dmc_addr_q   <= 16'h0000;
         db_out_q     <= 8'h00;
         from_dummy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= ~phase_q;
         oam_pend_q   <= oam_pend_d;
         dmc_pend_q   <= dmc_pend_d;
         cnt_q        <= cnt_d;
         page_q       <= page_d;
         dmc_addr_q   <= dmc_addr_d;
         db_out_q     <= db_out_d;
         from_dummy_q <= (state_q == ST_DUMMY);
      end
   end

   // Pending flags, captured addresses, byte counter and GET data latch.
   always_comb begin
      oam_pend_d = oam_pend_q;
      dmc_pend_d = dmc_pend_q;
      cnt_d      = cnt_q;
      page_d     = page_q;
      dmc_addr_d = dmc_addr_q;
      db_out_d   = db_out_q;
      if (state_q == ST_OAM_PUT && oam_last) oam_pend_d = 1'b0;
      if (state_q == ST_DMC_GET)             dmc_pend_d = 1'b0;
      if (oam_accept) begin
         oam_pend_d = 1'b1;
         page_d     = OAM_PAGE;
         cnt_d      = 8'h00;
      end else if (state_q == ST_OAM_PUT) begin
         cnt_d = cnt_q + 8'd1;
      end
      if (dmc_accept) begin
         dmc_pend_d = 1'b1;
         dmc_addr_d = DMC_ADDR;
      end
      if (state_q == ST_OAM_GET) db_out_d = DB_IN;
   end

   // Next state. phase_q == 1 means the coming cycle is a GET slot.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (oam_pend_q || dmc_pend_q) state_d = ST_HALT;
         end
         ST_HALT: begin
            // Core writes cannot be stalled; wait for its first read cycle.
            if (!CPU_WR) begin
               if (dmc_pend_q)      state_d = ST_DUMMY;
               else if (oam_pend_q) state_d = phase_q ? ST_OAM_GET : ST_ALIGN;
               else                 state_d = ST_IDLE;
            end
         end
         ST_DUMMY: begin
            state_d = phase_q ? ST_DMC_GET : ST_ALIGN;
         end
         ST_ALIGN: begin
            // ALIGN always sits on a PUT slot; what follows depends on
            // whether it was padding a DMC fetch or an OAM GET.
            state_d = from_dummy_q ? ST_DMC_GET : ST_OAM_GET;
         end
         ST_OAM_GET: begin
            state_d = ST_OAM_PUT;
         end
         ST_OAM_PUT: begin
            if (oam_last) state_d = dmc_pend_q ? ST_DUMMY : ST_IDLE;
`ifdef DMA_DMC_STEAL_EN
            else if (dmc_pend_q) state_d = ST_DMC_GET;
`endif
            else state_d = ST_OAM_GET;
         end
         ST_DMC_GET: begin
            // DMC_GET is on a GET slot, so resuming OAM needs one ALIGN.
            state_d = oam_pend_q ? ST_ALIGN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs are decoded from the registered state.
   always_comb begin
      DMA_OWN  = 1'b0;
      DMA_ADDR = 16'h0000;
      DMA_RD   = 1'b0;
      DMA_WR   = 1'b0;
      DMC_ACK  = 1'b0;
      case (state_q)
         ST_DUMMY, ST_ALIGN: DMA_OWN = 1'b1;
         ST_OAM_GET: begin
            DMA_OWN  = 1'b1;
            DMA_RD   = 1'b1;
            DMA_ADDR = {page_q, cnt_q};
         end
         ST_OAM_PUT: begin
            DMA_OWN  = 1'b1;
            DMA_WR   = 1'b1;
            DMA_ADDR = OAM_PORT;
         end
         ST_DMC_GET: begin
            DMA_OWN  = 1'b1;
            DMA_RD   = 1'b1;
            DMA_ADDR = dmc_addr_q;
            DMC_ACK  = 1'b1;
         end
         default: ;
      endcase
   end

   assign RDY       = (state_q == ST_IDLE);
   assign DB_OUT    = db_out_q;
   assign PHASE     = phase_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
`timescale 1ns/1ps
module tb_dma_bus_arbiter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        n_res;
   logic        cpu_wr;
   logic        oam_req;
   logic [7:0]  oam_page;
   logic        dmc_req;
   logic [15:0] dmc_addr;
   logic [7:0]  db_in;
   logic        rdy;
   logic        dma_own;
   logic [15:0] dma_addr;
   logic        dma_rd;
   logic        dma_wr;
   logic [7:0]  db_out;
   logic        dmc_ack;
   logic        phase;
   logic [2:0]  dbg_state;

   dma_bus_arbiter dut (
      .CLK       (clk),
      .n_RES     (n_res),
      .CPU_WR    (cpu_wr),
      .OAM_REQ   (oam_req),
      .OAM_PAGE  (oam_page),
      .DMC_REQ   (dmc_req),
      .DMC_ADDR  (dmc_addr),
      .DB_IN     (db_in),
      .RDY       (rdy),
      .DMA_OWN   (dma_own),
      .DMA_ADDR  (dma_addr),
      .DMA_RD    (dma_rd),
      .DMA_WR    (dma_wr),
      .DB_OUT    (db_out),
      .DMC_ACK   (dmc_ack),
      .PHASE     (phase),
      .DBG_STATE (dbg_state)
   );

   // Memory model: every address returns a distinct, recomputable byte.
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   always_comb db_in = mem_byte(dma_addr);

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic        exp_phase;
   int          stall, halts, nrd, nwr, nack;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CPU cycle: outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      exp_phase = ~exp_phase;
      chk("phase", phase, exp_phase);
   endtask

   task automatic go_phase(input logic p);
      if (exp_phase !== p) tick();
   endtask

   task automatic push_oam(input logic [7:0] page, input int from, input int to);
      for (int i = from; i <= to; i++) exp_q.push_back({page, 8'(i)});
   endtask

   // Drives one transaction (request already set up for the current cycle)
   // and watches it until RDY returns high. wr_n = number of halt-phase
   // cycles the core spends writing; inj_at = stall cycle index in which a
   // DMC request pulse is injected (-1 for none).
   task automatic run_xfer(input int wr_n, input int inj_at, input logic [15:0] inj_addr);
      int   s;
      int   guard;
      bit   done;
      logic [7:0] last_get;
      s = 0; guard = 0; done = 0; last_get = db_out;
      halts = 0; nrd = 0; nwr = 0; nack = 0;
      cpu_wr = (wr_n > 0);
      while (!done && guard < 1200) begin
         tick();
         guard++;
         oam_req = 1'b0;
         dmc_req = 1'b0;
         if (rdy === 1'b0) begin
            s++;
            if (!dma_own) halts++;
            if (dma_rd) begin
               nrd++;
               if (exp_q.size() != 0) chk("rd_addr", dma_addr, exp_q.pop_front());
               if (dmc_ack) nack++;
               else         last_get = mem_byte(dma_addr);
            end else if (dmc_ack) begin
               chk("ack_without_rd", dma_rd, 1'b1);
            end
            if (dma_wr) begin
               nwr++;
               chk("wr_addr", dma_addr, 16'h2004);
               chk("wr_data", db_out, last_get);
            end
            cpu_wr = (s <= wr_n);
            if (s == inj_at) begin
               dmc_req  = 1'b1;
               dmc_addr = inj_addr;
            end
         end else if (s > 0) begin
            done = 1;
         end
      end
      chk("xfer_done", done, 1'b1);
      chk("own_after_release", dma_own, 1'b0);
      chk("exp_q_left", exp_q.size(), 0);
      exp_q.delete();
      cpu_wr = 1'b0;
      stall = s;
   endtask

   task automatic chk_xfer(input string tag, input int e_stall, input int e_halts,
                           input int e_rd, input int e_wr, input int e_ack);
      chk({tag, "_stall"}, stall, e_stall);
      chk({tag, "_halts"}, halts, e_halts);
      chk({tag, "_reads"}, nrd, e_rd);
      chk({tag, "_writes"}, nwr, e_wr);
      chk({tag, "_acks"}, nack, e_ack);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_res = 1'b0; cpu_wr = 1'b0; oam_req = 1'b0; oam_page = 8'h00;
      dmc_req = 1'b0; dmc_addr = 16'h0000;
      exp_phase = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy", rdy, 1'b1);
      chk("rst_own", dma_own, 1'b0);
      chk("rst_addr", dma_addr, 16'h0000);
      chk("rst_rd", dma_rd, 1'b0);
      chk("rst_wr", dma_wr, 1'b0);
      chk("rst_db_out", db_out, 8'h00);
      chk("rst_ack", dmc_ack, 1'b0);
      chk("rst_phase", phase, 1'b0);
      chk("rst_state", dbg_state, 3'd0);
      @(negedge clk);
      n_res = 1'b1;

      // OAM page 0x02 requested on a PUT cycle: halt lands GET-aligned.
      go_phase(1'b1);
      push_oam(8'h02, 0, 255);
      oam_page = 8'h02; oam_req = 1'b1;
      run_xfer(0, -1, 16'h0000);
      chk_xfer("oam_p02", 513, 1, 256, 256, 0);

      // Core writing for 3 cycles delays the halt; halt then needs ALIGN.
      repeat (3) tick();
      go_phase(1'b1);
      push_oam(8'h03, 0, 255);
      oam_page = 8'h03; oam_req = 1'b1;
      run_xfer(3, -1, 16'h0000);
      chk_xfer("oam_wr3", 517, 4, 256, 256, 0);

      // Lone DMC fetch, requested on PUT: HALT, DUMMY, ALIGN, GET.
      repeat (2) tick();
      go_phase(1'b1);
      exp_q.push_back(16'hC000);
      dmc_addr = 16'hC000; dmc_req = 1'b1;
      run_xfer(0, -1, 16'h0000);
      chk_xfer("dmc_c000", 4, 1, 1, 0, 1);
      chk("dmc_keeps_db_out", db_out, mem_byte(16'h03FF));

      // Lone DMC fetch, requested on GET: no ALIGN needed.
      repeat (2) tick();
      go_phase(1'b0);
      exp_q.push_back(16'hC123);
      dmc_addr = 16'hC123; dmc_req = 1'b1;
      run_xfer(0, -1, 16'h0000);
      chk_xfer("dmc_c123", 3, 1, 1, 0, 1);

      // DMC request arriving mid OAM copy (during GET of byte 0x0F).
      repeat (2) tick();
      go_phase(1'b1);
`ifdef DMA_DMC_STEAL_EN
      push_oam(8'h05, 0, 15);
      exp_q.push_back(16'hD0D0);
      push_oam(8'h05, 16, 255);
`else
      push_oam(8'h05, 0, 255);
      exp_q.push_back(16'hD0D0);
`endif
      oam_page = 8'h05; oam_req = 1'b1;
      run_xfer(0, 32, 16'hD0D0);
`ifdef DMA_DMC_STEAL_EN
      chk_xfer("oam_dmc_mid", 515, 1, 257, 256, 1);
`else
      chk_xfer("oam_dmc_mid", 516, 1, 257, 256, 1);
`endif

      // OAM and DMC in the same cycle: DMC first, one shared halt cycle.
      repeat (2) tick();
      go_phase(1'b0);
      exp_q.push_back(16'hC000);
      push_oam(8'h04, 0, 255);
      oam_page = 8'h04; oam_req = 1'b1;
      dmc_addr = 16'hC000; dmc_req = 1'b1;
      run_xfer(0, -1, 16'h0000);
      chk_xfer("oam_dmc_same", 516, 1, 257, 256, 1);

      // Reset in the middle of an OAM copy at byte 0x40.
      repeat (2) tick();
      go_phase(1'b1);
      oam_page = 8'h06; oam_req = 1'b1;
      tick();
      oam_req = 1'b0;
      tick();
      repeat (129) tick();
      chk("mid_rd", dma_rd, 1'b1);
      chk("mid_addr", dma_addr, 16'h0640);
      #2 n_res = 1'b0;
      #1;
      chk("abort_rdy", rdy, 1'b1);
      chk("abort_own", dma_own, 1'b0);
      chk("abort_rd", dma_rd, 1'b0);
      chk("abort_wr", dma_wr, 1'b0);
      chk("abort_phase", phase, 1'b0);
      @(posedge clk);
      @(negedge clk);
      n_res = 1'b1;
      exp_phase = 1'b0;
      repeat (20) begin
         tick();
         chk("post_abort_wr", dma_wr, 1'b0);
         chk("post_abort_own", dma_own, 1'b0);
         chk("post_abort_rdy", rdy, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
